// File: rtl/ps2_scan_decoder.sv
// PS/2 scancode decoder: pops bytes from an upstream receiver FIFO, tracks
// make/break/extended sequences, keeps the last pressed key, its ASCII
// value and a press counter, and drives six active-low 7-segment digits.
module ps2_scan_decoder (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] ps2_data,
    input  logic       ps2_ready,
    input  logic       ps2_overflow,
    output logic       ps2_nextdata_n,
    output logic       key_down,
    output logic [7:0] scancode,
    output logic [7:0] ascii,
    output logic [7:0] key_count,
    output logic       ovf_seen,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [7:0] seg3,
    output logic [7:0] seg4,
    output logic [7:0] seg5
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_HELD       = 2'd1,
        S_BREAK_PEND = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       nextdata_n_q, nextdata_n_d;
    logic       key_down_q, key_down_d;
    logic [7:0] scancode_q, scancode_d;
    logic [7:0] ascii_q, ascii_d;
    logic [7:0] key_count_q, key_count_d;
    logic       ovf_seen_q;
    logic       consume;

    // Make-code to uppercase ASCII; anything unmapped yields 8'h00.
    function automatic logic [7:0] ascii_map(input logic [7:0] code);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
            8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
            8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
            8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
            8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
            8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Hex nibble to active-low glyph {dp,g,f,e,d,c,b,a}; dp stays off.
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'hC0; 4'h1: g = 8'hF9; 4'h2: g = 8'hA4; 4'h3: g = 8'hB0;
            4'h4: g = 8'h99; 4'h5: g = 8'h92; 4'h6: g = 8'h82; 4'h7: g = 8'hF8;
            4'h8: g = 8'h80; 4'h9: g = 8'h90; 4'hA: g = 8'h88; 4'hB: g = 8'h83;
            4'hC: g = 8'hC6; 4'hD: g = 8'hA1; 4'hE: g = 8'h86; default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // The byte at the FIFO head is taken at the end of the cycle in which the
    // pop strobe is low, even if ps2_ready has dropped meanwhile.
    assign consume = ~nextdata_n_q;

    // Next-state logic: pop strobe generation and make/break/repeat decoding.
    always_comb begin
        state_d      = state_q;
        key_down_d   = key_down_q;
        scancode_d   = scancode_q;
        ascii_d      = ascii_q;
        key_count_d  = key_count_q;
        // Strobe low only after a high cycle, so pops are at least two cycles apart.
        nextdata_n_d = ~(ps2_ready & nextdata_n_q);

        if (consume && ps2_data != 8'hE0) begin
            if (ps2_data == 8'hF0) begin
                state_d = S_BREAK_PEND;
            end else if (state_q == S_BREAK_PEND) begin
                if (ps2_data == scancode_q) begin
                    state_d    = S_IDLE;
                    key_down_d = 1'b0;
                end else begin
                    // Release of some other key: keep showing the current one.
                    state_d = key_down_q ? S_HELD : S_IDLE;
                end
            end else if (ps2_data != scancode_q || !key_down_q) begin
                state_d     = S_HELD;
                key_down_d  = 1'b1;
                scancode_d  = ps2_data;
                ascii_d     = ascii_map(ps2_data);
                key_count_d = key_count_q + 8'd1;
            end
            // Otherwise a typematic repeat of the held key: nothing changes.
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            nextdata_n_q <= 1'b1;
            key_down_q   <= 1'b0;
            scancode_q   <= 8'h00;
            ascii_q      <= 8'h00;
            key_count_q  <= 8'h00;
            ovf_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            nextdata_n_q <= nextdata_n_d;
            key_down_q   <= key_down_d;
            scancode_q   <= scancode_d;
            ascii_q      <= ascii_d;
            key_count_q  <= key_count_d;
            ovf_seen_q   <= ovf_seen_q | ps2_overflow;
        end
    end

    assign ps2_nextdata_n = nextdata_n_q;
    assign key_down       = key_down_q;
    assign scancode       = scancode_q;
    assign ascii          = ascii_q;
    assign key_count      = key_count_q;
    assign ovf_seen       = ovf_seen_q;

    // Key digits blank when nothing is held; the counter is always shown.
    assign seg0 = key_down_q ? hex_glyph(scancode_q[3:0]) : 8'hFF;
    assign seg1 = key_down_q ? hex_glyph(scancode_q[7:4]) : 8'hFF;
    assign seg2 = key_down_q ? hex_glyph(ascii_q[3:0])    : 8'hFF;
    assign seg3 = key_down_q ? hex_glyph(ascii_q[7:4])    : 8'hFF;
    assign seg4 = hex_glyph(key_count_q[3:0]);
    assign seg5 = hex_glyph(key_count_q[7:4]);

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed testbench for ps2_scan_decoder: feeds scancode bytes through a
// simple FIFO-side handshake and checks outputs against hand-computed values.
module tb_ps2_scan_decoder;

    logic       clk;
    logic       resetn;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       ps2_nextdata_n;
    logic       key_down;
    logic [7:0] scancode;
    logic [7:0] ascii;
    logic [7:0] key_count;
    logic       ovf_seen;
    logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;

    int n_cmp = 0;
    int n_err = 0;

    ps2_scan_decoder dut (
        .clk            (clk),
        .resetn         (resetn),
        .ps2_data       (ps2_data),
        .ps2_ready      (ps2_ready),
        .ps2_overflow   (ps2_overflow),
        .ps2_nextdata_n (ps2_nextdata_n),
        .key_down       (key_down),
        .scancode       (scancode),
        .ascii          (ascii),
        .key_count      (key_count),
        .ovf_seen       (ovf_seen),
        .seg0           (seg0),
        .seg1           (seg1),
        .seg2           (seg2),
        .seg3           (seg3),
        .seg4           (seg4),
        .seg5           (seg5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        ps2_ready = 1'b0; ps2_overflow = 1'b0; ps2_data = 8'h00;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Presents one byte, waits (bounded) for the pop strobe, and returns at the
    // negedge after the consuming edge. drop_ready releases ready during the pop.
    task automatic send_byte(input logic [7:0] b, input bit drop_ready);
        bit got;
        int i;
        @(negedge clk);
        ps2_data = b; ps2_ready = 1'b1;
        got = 0; i = 0;
        while (!got && i < 8) begin
            @(negedge clk);
            if (ps2_nextdata_n === 1'b0) got = 1;
            i++;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL pop_timeout byte=%h: nextdata_n never went low", b);
            ps2_ready = 1'b0;
        end else begin
            if (drop_ready) ps2_ready = 1'b0;
            @(negedge clk);
            ps2_ready = 1'b0;
        end
        $display("byte %h sent: key_down=%b scancode=%h ascii=%h count=%h", b, key_down, scancode, ascii, key_count);
    endtask

    task automatic test_reset();
        ps2_data = 8'h00; ps2_ready = 1'b0; ps2_overflow = 1'b0;
        resetn = 1'b0;
        #12;
        n_cmp++; if ({key_down, scancode, ascii, key_count} !== 25'h0) begin n_err++; $display("FAIL reset_regs got %b/%h/%h/%h want 0/00/00/00", key_down, scancode, ascii, key_count); end
        n_cmp++; if ({ovf_seen, ps2_nextdata_n} !== 2'b01) begin n_err++; $display("FAIL reset_flags got ovf=%b nd=%b want 0/1", ovf_seen, ps2_nextdata_n); end
        n_cmp++; if ({seg0, seg1, seg2, seg3} !== 32'hFFFFFFFF) begin n_err++; $display("FAIL reset_seg03 got %h %h %h %h want FF", seg0, seg1, seg2, seg3); end
        n_cmp++; if ({seg4, seg5} !== 16'hC0C0) begin n_err++; $display("FAIL reset_seg45 got %h %h want C0 C0", seg4, seg5); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_press();
        bit got;
        int i;
        do_reset();
        ps2_data = 8'h1C; ps2_ready = 1'b1;
        got = 0; i = 0;
        while (!got && i < 8) begin
            @(negedge clk);
            if (ps2_nextdata_n === 1'b0) got = 1;
            i++;
        end
        n_cmp++; if (!got) begin n_err++; $display("FAIL single_pop no strobe within 8 cycles"); end
        @(negedge clk);
        ps2_ready = 1'b0;
        n_cmp++; if (ps2_nextdata_n !== 1'b1) begin n_err++; $display("FAIL single_strobe_width nd=%b want 1", ps2_nextdata_n); end
        n_cmp++; if ({key_down, scancode, ascii, key_count} !== {1'b1, 8'h1C, 8'h41, 8'h01}) begin n_err++; $display("FAIL single_regs got %b/%h/%h/%h want 1/1C/41/01", key_down, scancode, ascii, key_count); end
        n_cmp++; if ({seg0, seg1, seg2, seg3} !== 32'hC6F9F999) begin n_err++; $display("FAIL single_seg03 got %h %h %h %h want C6 F9 F9 99", seg0, seg1, seg2, seg3); end
        n_cmp++; if ({seg4, seg5} !== 16'hF9C0) begin n_err++; $display("FAIL single_seg45 got %h %h want F9 C0", seg4, seg5); end
        @(negedge clk);
        n_cmp++; if (ps2_nextdata_n !== 1'b1) begin n_err++; $display("FAIL single_idle nd=%b want 1", ps2_nextdata_n); end
    endtask

    task automatic test_typematic();
        do_reset();
        send_byte(8'h1C, 0); send_byte(8'h1C, 0); send_byte(8'h1C, 0);
        n_cmp++; if ({key_down, key_count} !== {1'b1, 8'h01}) begin n_err++; $display("FAIL typematic_repeat got %b/%h want 1/01", key_down, key_count); end
        send_byte(8'hF0, 0);
        n_cmp++; if (key_down !== 1'b1) begin n_err++; $display("FAIL typematic_f0_hold key_down=%b want 1", key_down); end
        send_byte(8'h1C, 0);
        n_cmp++; if ({key_down, key_count} !== {1'b0, 8'h01}) begin n_err++; $display("FAIL typematic_release got %b/%h want 0/01", key_down, key_count); end
        n_cmp++; if ({seg0, seg1, seg2, seg3, seg4, seg5} !== 48'hFFFFFFFFF9C0) begin n_err++; $display("FAIL typematic_seg got %h %h %h %h %h %h want FF FF FF FF F9 C0", seg0, seg1, seg2, seg3, seg4, seg5); end
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0, 0);
        n_cmp++; if ({key_down, key_count} !== {1'b0, 8'h00}) begin n_err++; $display("FAIL ext_e0_ignored got %b/%h want 0/00", key_down, key_count); end
        send_byte(8'h75, 0); send_byte(8'hE0, 0); send_byte(8'hF0, 0);
        send_byte(8'h75, 0);
        n_cmp++; if ({key_down, scancode, ascii, key_count} !== {1'b0, 8'h75, 8'h00, 8'h01}) begin n_err++; $display("FAIL ext_final got %b/%h/%h/%h want 0/75/00/01", key_down, scancode, ascii, key_count); end
    endtask

    task automatic test_break_mismatch();
        do_reset();
        send_byte(8'h1C, 0); send_byte(8'hF0, 0); send_byte(8'h32, 0);
        n_cmp++; if ({key_down, scancode, ascii, key_count} !== {1'b1, 8'h1C, 8'h41, 8'h01}) begin n_err++; $display("FAIL brk_other got %b/%h/%h/%h want 1/1C/41/01", key_down, scancode, ascii, key_count); end
        send_byte(8'h1C, 0);
        n_cmp++; if (key_count !== 8'h01) begin n_err++; $display("FAIL brk_back_to_held count=%h want 01", key_count); end
        send_byte(8'h32, 0);
        n_cmp++; if ({key_down, scancode, ascii, key_count} !== {1'b1, 8'h32, 8'h42, 8'h02}) begin n_err++; $display("FAIL brk_new_key got %b/%h/%h/%h want 1/32/42/02", key_down, scancode, ascii, key_count); end
    endtask

    task automatic test_ascii();
        logic [7:0] codes [5];
        logic [7:0] want  [5];
        codes = '{8'h29, 8'h5A, 8'h45, 8'h1A, 8'h66};
        want  = '{8'h20, 8'h0D, 8'h30, 8'h5A, 8'h00};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_byte(codes[k], 0);
            n_cmp++;
            if ({scancode, ascii, key_count} !== {codes[k], want[k], 8'(k + 1)}) begin
                n_err++;
                $display("FAIL ascii_%0d got %h/%h/%h want %h/%h/%h", k, scancode, ascii, key_count, codes[k], want[k], 8'(k + 1));
            end
            if (k == 1) begin
                n_cmp++; if ({seg0, seg1, seg2, seg3} !== 32'h8892A1C0) begin n_err++; $display("FAIL ascii_enter_seg got %h %h %h %h want 88 92 A1 C0", seg0, seg1, seg2, seg3); end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 256; k++) begin
            send_byte(8'h16, 0); send_byte(8'hF0, 0); send_byte(8'h16, 0);
            if (k == 254) begin
                n_cmp++; if ({key_count, seg4, seg5} !== 24'hFF8E8E) begin n_err++; $display("FAIL wrap_ff got %h %h %h want FF 8E 8E", key_count, seg4, seg5); end
            end
        end
        n_cmp++; if ({key_down, key_count, seg4, seg5} !== {1'b0, 24'h00C0C0}) begin n_err++; $display("FAIL wrap_zero got %b %h %h %h want 0 00 C0 C0", key_down, key_count, seg4, seg5); end
    endtask

    task automatic test_back_to_back();
        logic prev;
        do_reset();
        ps2_data = 8'hE0; ps2_ready = 1'b1;
        prev = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ps2_nextdata_n !== ((k % 2 == 0) ? 1'b0 : 1'b1)) begin
                n_err++;
                $display("FAIL b2b_cycle%0d nd=%b want %b", k, ps2_nextdata_n, (k % 2 == 0) ? 1'b0 : 1'b1);
            end
            if (prev === 1'b0 && ps2_nextdata_n === 1'b0) begin
                n_err++;
                $display("FAIL b2b_double_low cycle%0d nd=0 prev=0 want a high between", k);
            end
            prev = ps2_nextdata_n;
        end
        ps2_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({ps2_nextdata_n, key_count} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL b2b_after got nd=%b count=%h want 1/00", ps2_nextdata_n, key_count); end
        $display("back_to_back done");
    endtask

    task automatic test_ready_drop();
        do_reset();
        send_byte(8'h24, 1);
        n_cmp++; if ({key_down, scancode, ascii, key_count} !== {1'b1, 8'h24, 8'h45, 8'h01}) begin n_err++; $display("FAIL ready_drop got %b/%h/%h/%h want 1/24/45/01", key_down, scancode, ascii, key_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        ps2_overflow = 1'b1;
        @(negedge clk);
        ps2_overflow = 1'b0;
        n_cmp++; if (ovf_seen !== 1'b1) begin n_err++; $display("FAIL ovf_set ovf_seen=%b want 1", ovf_seen); end
        send_byte(8'h1C, 0);
        repeat (5) @(negedge clk);
        n_cmp++; if ({ovf_seen, key_count} !== {1'b1, 8'h01}) begin n_err++; $display("FAIL ovf_sticky got %b/%h want 1/01", ovf_seen, key_count); end
        do_reset();
        n_cmp++; if (ovf_seen !== 1'b0) begin n_err++; $display("FAIL ovf_cleared ovf_seen=%b want 0", ovf_seen); end
        $display("overflow done");
    endtask

    task automatic test_reset_mid();
        int i;
        do_reset();
        send_byte(8'h1C, 0); send_byte(8'hF0, 0);
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if ({key_down, key_count, seg4, seg0} !== {1'b0, 8'h00, 8'hC0, 8'hFF}) begin n_err++; $display("FAIL rstmid_async got %b %h %h %h want 0 00 C0 FF", key_down, key_count, seg4, seg0); end
        @(negedge clk);
        resetn = 1'b1;
        send_byte(8'h1C, 0);
        n_cmp++; if ({key_down, key_count, scancode} !== {1'b1, 8'h01, 8'h1C}) begin n_err++; $display("FAIL rstmid_press got %b/%h/%h want 1/01/1C", key_down, key_count, scancode); end
        // Reset while the pop strobe is low must release it immediately.
        @(negedge clk);
        ps2_data = 8'h32; ps2_ready = 1'b1;
        i = 0;
        while (ps2_nextdata_n !== 1'b0 && i < 8) begin @(negedge clk); i++; end
        ps2_ready = 1'b0;
        #1 resetn = 1'b0;
        #1;
        n_cmp++; if ({ps2_nextdata_n, key_count} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL rstpop got nd=%b count=%h want 1/00", ps2_nextdata_n, key_count); end
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({key_down, key_count} !== {1'b0, 8'h00}) begin n_err++; $display("FAIL rstpop_after got %b/%h want 0/00", key_down, key_count); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_typematic();
        test_extended();
        test_break_mismatch();
        test_ascii();
        test_ready_drop();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
